// File: rtl/ysyx_25050147_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25050147_ifu
// Purpose  : Instruction fetch unit. Owns the fetch PC, issues one fetch
//            request at a time to the instruction bus, waits for a response
//            of arbitrary latency and hands the word and its PC to the IDU
//            over a valid/ready handshake. Takes next-PC redirects from
//            execute and flushes, drops stale responses and reports bus
//            errors, bus timeouts and misaligned PCs through a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25050147_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The timer must be able to hold TIMEOUT itself so it can saturate there.
    localparam int                  c_TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_SAT  = c_TIMER_W'(TIMEOUT);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
    // Word presented to the decoder once the unit has faulted (addi x0,x0,0).
    localparam logic [31:0]          c_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [31:0]            r_fetch_pc;
    logic                   r_drop;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_inst_valid;
    logic [31:0]            r_inst;
    logic [31:0]            r_inst_pc;
    logic                   r_fetch_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_flush_misaligned;
    logic [31:0]            w_next_pc;
    logic                   w_next_misaligned;
    logic [c_TIMER_W-1:0]   w_timer_inc;
    logic                   w_timer_expired;

    // Sequential successor of the held word: redirect target or PC+4 (wraps).
    assign w_next_pc          = redirect_valid ? redirect_addr : (r_inst_pc + 32'd4);
    assign w_next_misaligned  = (w_next_pc[1:0] != 2'b00);
    assign w_flush_misaligned = (flush_addr[1:0] != 2'b00);
    // Saturating increment so a long wait can never wrap back below the limit.
    assign w_timer_inc        = (r_timer == c_TIMER_SAT) ? r_timer : (r_timer + c_TIMER_ONE);
    assign w_timer_expired    = (r_timer >= c_TIMER_LAST);

    // ------------------------------------------------------------------------
    // Outputs: everything is forced low while reset is held, so nothing
    // leaks out of the reset cycle before the registers have been cleared.
    // ------------------------------------------------------------------------
    assign mem_req_valid = !rst && (r_state == S_REQ);
    assign mem_req_addr  = rst ? 32'd0 : r_fetch_pc;
    assign inst_valid    = !rst && r_inst_valid;
    assign inst          = rst ? 32'd0 : r_inst;
    assign inst_pc       = rst ? 32'd0 : r_inst_pc;
    assign fetch_err     = !rst && r_fetch_err;

    // Fetch FSM: request, wait for response, hold for the IDU, or sit faulted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_drop       <= 1'b0;
            r_timer      <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                // ------------------------------------------------------------
                S_REQ: begin
                    if (flush) begin
                        if (w_flush_misaligned) begin
                            r_state      <= S_ERR;
                            r_fetch_pc   <= flush_addr;
                            r_drop       <= 1'b0;
                            r_inst_valid <= 1'b1;
                            r_fetch_err  <= 1'b1;
                            r_inst       <= c_NOP;
                            r_inst_pc    <= flush_addr;
                        end else begin
                            // The old address may already have been accepted
                            // this cycle; its response must then be thrown away.
                            r_fetch_pc <= flush_addr;
                            if (mem_req_ready) begin
                                r_state <= S_WAIT;
                                r_timer <= '0;
                                r_drop  <= 1'b1;
                            end
                        end
                    end else if (mem_req_ready) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                        r_drop  <= 1'b0;
                    end
                end
                // ------------------------------------------------------------
                S_WAIT: begin
                    if (flush) begin
                        if (w_flush_misaligned) begin
                            r_state      <= S_ERR;
                            r_fetch_pc   <= flush_addr;
                            r_drop       <= 1'b0;
                            r_inst_valid <= 1'b1;
                            r_fetch_err  <= 1'b1;
                            r_inst       <= c_NOP;
                            r_inst_pc    <= flush_addr;
                        end else if (mem_resp_valid) begin
                            // The response in flight lands now and is discarded.
                            r_fetch_pc <= flush_addr;
                            r_drop     <= 1'b0;
                            r_state    <= S_REQ;
                        end else begin
                            r_fetch_pc <= flush_addr;
                            r_drop     <= 1'b1;
                            r_timer    <= w_timer_inc;
                        end
                    end else if (mem_resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else if (mem_resp_err) begin
                            r_state      <= S_ERR;
                            r_inst_valid <= 1'b1;
                            r_fetch_err  <= 1'b1;
                            r_inst       <= c_NOP;
                            r_inst_pc    <= r_fetch_pc;
                        end else begin
                            r_state      <= S_HOLD;
                            r_inst_valid <= 1'b1;
                            r_inst       <= mem_resp_data;
                            r_inst_pc    <= r_fetch_pc;
                        end
                    end else if (w_timer_expired) begin
                        r_state      <= S_ERR;
                        r_drop       <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_fetch_err  <= 1'b1;
                        r_inst       <= c_NOP;
                        r_inst_pc    <= r_fetch_pc;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                // ------------------------------------------------------------
                S_HOLD: begin
                    if (flush) begin
                        // Flush beats a same-cycle handshake: the word is lost.
                        if (w_flush_misaligned) begin
                            r_state      <= S_ERR;
                            r_fetch_pc   <= flush_addr;
                            r_inst_valid <= 1'b1;
                            r_fetch_err  <= 1'b1;
                            r_inst       <= c_NOP;
                            r_inst_pc    <= flush_addr;
                        end else begin
                            r_state      <= S_REQ;
                            r_fetch_pc   <= flush_addr;
                            r_inst_valid <= 1'b0;
                        end
                    end else if (inst_ready) begin
                        if (w_next_misaligned) begin
                            r_state      <= S_ERR;
                            r_fetch_pc   <= w_next_pc;
                            r_inst_valid <= 1'b1;
                            r_fetch_err  <= 1'b1;
                            r_inst       <= c_NOP;
                            r_inst_pc    <= w_next_pc;
                        end else begin
                            r_state      <= S_REQ;
                            r_fetch_pc   <= w_next_pc;
                            r_inst_valid <= 1'b0;
                        end
                    end
                end
                // ------------------------------------------------------------
                S_ERR: begin
                    // Terminal until reset; flush, responses and handshakes
                    // leave the fault report untouched.
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
